// File: rtl/seq_div_ctrl_if.sv
// Request/response bundle between a requester and the seq_div_ctrl restoring divider.
// The master side issues start with operands; the slave side answers with busy/done and results.

// Handshake: start is a one-cycle request that is accepted only while the divider
// is idle (busy=0, done=0); it is ignored otherwise and never queued. busy is high
// for the whole iteration phase, done is a single-cycle pulse, and quotient,
// remainder and div_by_zero stay stable from that pulse until the next accepted start.
interface seq_div_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_ctrl.sv
// Unsigned restoring divider sequencer: one trial subtraction and one quotient bit per clock.
// Optional macro SEQ_DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes at once.
module seq_div_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4   // 2**CNT_W must exceed WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    seq_div_ctrl_if.slave     bus,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    // Trial subtraction for the current iteration.
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               borrow;
    logic [WIDTH:0]     iter_r;
    logic [WIDTH-1:0]   iter_q;

    assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_q};
    assign borrow  = (shifted < {1'b0, d_q});
    assign iter_r  = borrow ? shifted : trial;
    assign iter_q  = {q_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    r_d     = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ITER;
`ifdef SEQ_DIV_ZERO_FAST_EN
                    // Same result the full iteration would produce, without the wait.
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end

            ITER: begin
                r_d   = iter_r;
                q_d   = iter_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = iter_q;
                    rem_d   = iter_r[WIDTH-1:0];
                    dbz_d   = (d_q == '0);
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q == ITER);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state_o     = state_q;

    // Restoring invariant: the partial remainder stays below a nonzero divisor.
    a_rem_below_div: assert property (@(posedge clk) disable iff (rst)
        (state_q == ITER && d_q != '0) |-> (r_q < {1'b0, d_q}));

    a_done_single: assert property (@(posedge clk) disable iff (rst)
        (state_q == DONE) |=> (state_q != DONE));

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Randomised scoreboard bench for seq_div_ctrl: the driver predicts results and timing,
// a negedge monitor compares done, busy and the held result bus every cycle.
module tb_seq_div_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;
`ifdef SEQ_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    seq_div_ctrl_if #(.WIDTH(W)) bus ();

    seq_div_ctrl #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Clock-edge bookkeeping
    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Scoreboard state
    logic [2*W:0] exp_q[$];      // {div_by_zero, quotient, remainder}
    int           exp_cyc_q[$];  // cycle in which done must be seen
    logic [2*W:0] held = '0;
    int           busy_lo = 1;
    int           busy_hi = 0;
    int           next_free = 0;
    bit           seen_reset = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_state_changes = 0;
    logic [1:0]   prev_state = 2'd0;

    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        return {1'b0, W'(a / b), W'(a % b)};
    endfunction

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    // Monitor: compares outputs against the model once per cycle.
    always @(negedge clk) begin
        logic         exp_done;
        logic [2*W:0] got;
        if (dbg_state !== prev_state) n_state_changes++;
        prev_state = dbg_state;
        if (rst_seen) begin
            exp_q.delete();
            exp_cyc_q.delete();
            held       = '0;
            busy_lo    = 1;
            busy_hi    = 0;
            seen_reset = 1'b1;
        end
        if (seen_reset) begin
            exp_done = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            check1("done", bus.done, exp_done);
            if (exp_done) begin
                held = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end
            check1("busy", bus.busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            got = {bus.div_by_zero, bus.quotient, bus.remainder};
            n_checks++;
            if (got !== held) begin
                n_fail++;
                $display("FAIL result cyc=%0d got dbz=%b q=%0d r=%0d exp dbz=%b q=%0d r=%0d",
                         cyc, got[2*W], got[2*W-1:W], got[W-1:0],
                         held[2*W], held[2*W-1:W], held[W-1:0]);
            end
        end
    end

    // Driver: one call per clock; predicts acceptance, latency and result.
    task automatic drive_cycle(input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
        int e0;
        int lat;
        bus.start    = st;
        bus.dividend = a;
        bus.divisor  = b;
        e0 = cyc + 1;
        if (st && !rst && e0 >= next_free) begin
            lat = (FAST && b == '0) ? 0 : W;
            exp_q.push_back(ref_div(a, b));
            exp_cyc_q.push_back(e0 + lat);
            busy_lo   = e0;
            busy_hi   = e0 + lat - 1;
            next_free = e0 + lat + 2;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        while (cyc + 1 < next_free) drive_cycle(1'b0, W'($urandom), W'($urandom));
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        drive_cycle(1'b1, a, b);
        wait_idle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) drive_cycle(1'b0, '0, '0);
        rst = 1'b0;
        next_free = 0;
        drive_cycle(1'b0, '0, '0);
    endtask

    function automatic logic [W-1:0] rand_divisor();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return W'($urandom_range(1, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        @(posedge clk);
        #2;
        do_reset(3);

        // Directed cases
        run_div(8'd100, 8'd7);
        run_div(8'd255, 8'd1);
        run_div(8'd255, 8'd255);
        run_div(8'd5,   8'd9);
        run_div(8'd200, 8'd0);
        run_div(8'd0,   8'd3);

        // Start while busy: extra requests at cycles 3 and 6 must be ignored
        drive_cycle(1'b1, 8'd100, 8'd7);
        drive_cycle(1'b0, 8'd0,   8'd0);
        drive_cycle(1'b1, 8'd50,  8'd5);
        drive_cycle(1'b0, 8'd0,   8'd0);
        drive_cycle(1'b0, 8'd0,   8'd0);
        drive_cycle(1'b1, 8'd50,  8'd5);
        wait_idle();
        run_div(8'd50, 8'd5);

        // Reset during iteration discards the operation
        drive_cycle(1'b1, 8'd200, 8'd3);
        repeat (3) drive_cycle(1'b0, 8'd0, 8'd0);
        do_reset(1);
        run_div(8'd9, 8'd2);

        // Start held high: a new division every W+2 cycles
        repeat (60) drive_cycle(1'b1, W'($urandom), rand_divisor());
        wait_idle();

        // Random traffic with occasional resets
        repeat (2500) begin
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
            else drive_cycle($urandom_range(0, 3) == 0, W'($urandom), rand_divisor());
        end

        repeat (W + 4) drive_cycle(1'b0, '0, '0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("state transitions observed: %0d", n_state_changes);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
